// File: rtl/register_bank_writer.sv
// Write side of the 32-entry general-purpose register file: one-hot write decode,
// flat read bus for the read-port muxes, and a bulk-clear sweep back to reset values.
module register_bank_writer #(
  parameter int                     WORD_LENGTH = 32,
  parameter int                     NBITS       = 5,
  parameter logic [WORD_LENGTH-1:0] GP_INIT     = 32'h1000_8000,
  parameter logic [WORD_LENGTH-1:0] SP_INIT     = 32'h7FFF_FFFC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Write_Enable,
  input  logic [NBITS-1:0]          Write_Register,
  input  logic [WORD_LENGTH-1:0]    Write_Data,
  input  logic                      Clear_Req,
  output logic                      Write_Ack,
  output logic                      Busy,
  output logic [31:0]               Write_Onehot,
  output logic [32*WORD_LENGTH-1:0] Reg_Flat
);

  localparam int NREGS = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                 state, state_next;
  logic [NBITS-1:0]       counter;
  logic                   accept;
  logic [NREGS-1:0]       write_sel;
  logic [NREGS-1:0]       clear_sel;

  // Register 0 has no storage at all, so it can never be written.
  logic [WORD_LENGTH-1:0] regs [1:NREGS-1];

  function automatic logic [WORD_LENGTH-1:0] init_value(input int idx);
    if (idx == 28)      return GP_INIT;
    else if (idx == 29) return SP_INIT;
    else                return '0;
  endfunction

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    write_sel  = '0;
    clear_sel  = '0;
    case (state)
      IDLE: begin
        if (Clear_Req) begin
          state_next = CLEAR;
        end else if (Write_Enable) begin
          accept    = 1'b1;
          write_sel = (NREGS'(1) << Write_Register) & ~NREGS'(1);
        end
      end
      CLEAR: begin
        clear_sel = NREGS'(1) << counter;
        if (counter == NBITS'(NREGS - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      counter      <= '0;
      Write_Ack    <= 1'b0;
      Busy         <= 1'b0;
      Write_Onehot <= '0;
    end else begin
      state        <= state_next;
      Write_Ack    <= accept;
      Busy         <= (state_next == CLEAR);
      Write_Onehot <= write_sel;
      if (state == IDLE && Clear_Req) counter <= NBITS'(1);
      else if (state == CLEAR)        counter <= counter + 1'b1;
    end
  end

  // NOTE: the bank is plain flops, not a RAM, because every entry has a defined reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= init_value(i);
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (write_sel[i])      regs[i] <= Write_Data;
        else if (clear_sel[i]) regs[i] <= init_value(i);
      end
    end
  end

  always_comb begin
    Reg_Flat = '0;
    for (int i = 1; i < NREGS; i++) Reg_Flat[i*WORD_LENGTH +: WORD_LENGTH] = regs[i];
  end

endmodule

// File: tb/tb_register_bank_writer.sv
// Scoreboard bench for register_bank_writer: per-cycle expected handshake outputs are
// queued at drive time and compared after each edge; bank contents follow a reference model.
module tb_register_bank_writer;

  localparam logic [31:0] GP = 32'h1000_8000;
  localparam logic [31:0] SP = 32'h7FFF_FFFC;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          Write_Enable = 1'b0;
  logic [4:0]    Write_Register = '0;
  logic [31:0]   Write_Data = '0;
  logic          Clear_Req = 1'b0;
  logic          Write_Ack;
  logic          Busy;
  logic [31:0]   Write_Onehot;
  logic [1023:0] Reg_Flat;

  register_bank_writer dut (
    .clk            (clk),
    .reset          (reset),
    .Write_Enable   (Write_Enable),
    .Write_Register (Write_Register),
    .Write_Data     (Write_Data),
    .Clear_Req      (Clear_Req),
    .Write_Ack      (Write_Ack),
    .Busy           (Busy),
    .Write_Onehot   (Write_Onehot),
    .Reg_Flat       (Reg_Flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] onehot;
    logic        busy;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_regs [32];
  bit          m_busy;
  int          m_cnt;
  int          n_compared = 0;
  int          n_mismatched = 0;

  function automatic logic [31:0] exp_init(input int idx);
    if (idx == 28) return GP;
    if (idx == 29) return SP;
    return 32'h0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) exp_regs[i] = exp_init(i);
    m_busy = 1'b0;
    m_cnt  = 0;
    sb.delete();
  endfunction

  // Scoreboard monitor: pops the expectation queued for this edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_compared++;
      if (Write_Ack !== e.ack) begin
        n_mismatched++;
        $display("FAIL %s ack: got %b want %b", e.tag, Write_Ack, e.ack);
      end
      n_compared++;
      if (Write_Onehot !== e.onehot) begin
        n_mismatched++;
        $display("FAIL %s onehot: got %h want %h", e.tag, Write_Onehot, e.onehot);
      end
      n_compared++;
      if (Busy !== e.busy) begin
        n_mismatched++;
        $display("FAIL %s busy: got %b want %b", e.tag, Busy, e.busy);
      end
    end
  end

  // One clock of stimulus; the reference model computes what the edge should produce.
  task automatic cycle(input logic we, input logic [4:0] addr, input logic [31:0] data,
                       input logic clr, input string tag);
    exp_t e;
    @(negedge clk);
    Write_Enable   = we;
    Write_Register = addr;
    Write_Data     = data;
    Clear_Req      = clr;
    e.tag    = tag;
    e.ack    = 1'b0;
    e.onehot = '0;
    if (!m_busy) begin
      if (clr) begin
        m_busy = 1'b1;
        m_cnt  = 1;
      end else if (we) begin
        e.ack = 1'b1;
        if (addr != 0) begin
          e.onehot       = 32'd1 << addr;
          exp_regs[addr] = data;
        end
      end
    end else begin
      exp_regs[m_cnt] = exp_init(m_cnt);
      if (m_cnt == 31) m_busy = 1'b0;
      m_cnt++;
    end
    e.busy = m_busy;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_compared++;
    if (Busy !== 1'b0 || Write_Ack !== 1'b0 || Write_Onehot !== 32'h0) begin
      n_mismatched++;
      $display("FAIL reset_outputs: got busy=%b ack=%b onehot=%h want 0 0 0", Busy, Write_Ack, Write_Onehot);
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      n_compared++;
      if (Reg_Flat[i*32 +: 32] !== exp_regs[i]) begin
        n_mismatched++;
        $display("FAIL reset_bank reg%0d: got %h want %h", i, Reg_Flat[i*32 +: 32], exp_regs[i]);
      end
    end
    cycle(1'b0, 5'd0, 32'h0, 1'b0, "reset_idle");
  endtask

  task automatic test_single_write();
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, "wr5");
    n_compared++;
    if (Reg_Flat[5*32 +: 32] !== 32'hDEAD_BEEF) begin
      n_mismatched++;
      $display("FAIL wr5_data: got %h want %h", Reg_Flat[5*32 +: 32], 32'hDEAD_BEEF);
    end
    cycle(1'b0, 5'd0, 32'h0, 1'b0, "wr5_after");
  endtask

  task automatic test_write_zero();
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, "wr0");
    n_compared++;
    if (Reg_Flat[31:0] !== 32'h0) begin
      n_mismatched++;
      $display("FAIL wr0_data: got %h want %h", Reg_Flat[31:0], 32'h0);
    end
    cycle(1'b0, 5'd0, 32'h0, 1'b0, "wr0_after");
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 5'd3, 32'h1, 1'b0, "b2b_1");
    cycle(1'b1, 5'd3, 32'h2, 1'b0, "b2b_2");
    cycle(1'b1, 5'd4, 32'h3, 1'b0, "b2b_3");
    cycle(1'b0, 5'd0, 32'h0, 1'b0, "b2b_idle");
    n_compared++;
    if (Reg_Flat[3*32 +: 32] !== 32'h2 || Reg_Flat[4*32 +: 32] !== 32'h3) begin
      n_mismatched++;
      $display("FAIL b2b_data: got r3=%h r4=%h want 2 3", Reg_Flat[3*32 +: 32], Reg_Flat[4*32 +: 32]);
    end
  endtask

  task automatic test_bulk_clear();
    int busy_cycles = 0;
    for (int r = 1; r < 32; r++) cycle(1'b1, 5'(r), 32'hA5A5_A5A5, 1'b0, "fill");
    for (int i = 0; i < 32; i++) begin
      n_compared++;
      if (Reg_Flat[i*32 +: 32] !== exp_regs[i]) begin
        n_mismatched++;
        $display("FAIL fill_bank reg%0d: got %h want %h", i, Reg_Flat[i*32 +: 32], exp_regs[i]);
      end
    end
    cycle(1'b1, 5'd7, 32'h1234_5678, 1'b1, "clr_start");
    if (Busy) busy_cycles++;
    n_compared++;
    if (Reg_Flat[7*32 +: 32] !== 32'hA5A5_A5A5) begin
      n_mismatched++;
      $display("FAIL clr_drop_wr7: got %h want %h", Reg_Flat[7*32 +: 32], 32'hA5A5_A5A5);
    end
    for (int k = 0; k < 31; k++) begin
      cycle(1'b1, 5'd7, 32'h5555_0000 + 32'(k), (k == 3) ? 1'b1 : 1'b0, "clr_sweep");
      if (Busy) busy_cycles++;
    end
    cycle(1'b0, 5'd0, 32'h0, 1'b0, "clr_done");
    if (Busy) busy_cycles++;
    n_compared++;
    if (busy_cycles !== 31) begin
      n_mismatched++;
      $display("FAIL clr_busy_len: got %0d want %0d", busy_cycles, 31);
    end
    for (int i = 0; i < 32; i++) begin
      n_compared++;
      if (Reg_Flat[i*32 +: 32] !== exp_init(i)) begin
        n_mismatched++;
        $display("FAIL clr_bank reg%0d: got %h want %h", i, Reg_Flat[i*32 +: 32], exp_init(i));
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    cycle(1'b1, 5'd2, 32'h1111_2222, 1'b0, "pre_r2");
    cycle(1'b1, 5'd30, 32'h3030_3030, 1'b0, "pre_r30");
    cycle(1'b0, 5'd0, 32'h0, 1'b1, "mid_clr_start");
    repeat (10) cycle(1'b0, 5'd0, 32'h0, 1'b0, "mid_clr_sweep");
    for (int i = 0; i < 32; i++) begin
      n_compared++;
      if (Reg_Flat[i*32 +: 32] !== exp_regs[i]) begin
        n_mismatched++;
        $display("FAIL partial_sweep reg%0d: got %h want %h", i, Reg_Flat[i*32 +: 32], exp_regs[i]);
      end
    end
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    n_compared++;
    if (Busy !== 1'b0 || Write_Ack !== 1'b0 || Write_Onehot !== 32'h0) begin
      n_mismatched++;
      $display("FAIL midreset_outputs: got busy=%b ack=%b onehot=%h want 0 0 0", Busy, Write_Ack, Write_Onehot);
    end
    for (int i = 0; i < 32; i++) begin
      n_compared++;
      if (Reg_Flat[i*32 +: 32] !== exp_regs[i]) begin
        n_mismatched++;
        $display("FAIL midreset_bank reg%0d: got %h want %h", i, Reg_Flat[i*32 +: 32], exp_regs[i]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 5'd9, 32'h0BAD_F00D, 1'b0, "post_reset_wr9");
    n_compared++;
    if (Reg_Flat[9*32 +: 32] !== 32'h0BAD_F00D) begin
      n_mismatched++;
      $display("FAIL post_reset_wr9_data: got %h want %h", Reg_Flat[9*32 +: 32], 32'h0BAD_F00D);
    end
    cycle(1'b0, 5'd0, 32'h0, 1'b0, "post_reset_idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_write_zero();
    test_back_to_back();
    test_bulk_clear();
    test_reset_mid_clear();
    n_compared++;
    if (sb.size() != 0) begin
      n_mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/register_bank_writer.md
Name: register_bank_writer

Overview:
Write side of the pipeline's 32-entry general-purpose register file. It decodes the write-back register address into a one-hot enable, stores the data, and presents every register on a flat bus that feeds the 32-to-1 read-port multiplexers. It also runs a bulk-clear sequencer, so software or debug logic can return the bank to its post-reset state without asserting reset.

Parameters:
WORD_LENGTH, 32, bit width of each register
NBITS, 5, register address width (32 registers)
GP_INIT, 32'h1000_8000, value loaded into register 28 ($gp) at reset and during clear
SP_INIT, 32'h7FFF_FFFC, value loaded into register 29 ($sp) at reset and during clear

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
Write_Enable  input  1  write-back request; sampled on the rising edge of clk
Write_Register  input  NBITS  destination register address
Write_Data  input  WORD_LENGTH  data to write
Clear_Req  input  1  request to start a bulk clear; sampled on the rising edge of clk
Write_Ack  output  1  registered one-cycle pulse meaning the write sampled on the previous edge was accepted
Busy  output  1  high while the clear sequencer is running
Write_Onehot  output  32  registered one-hot of the last register actually updated by a write; all zeros otherwise
Reg_Flat  output  32*WORD_LENGTH  all registers, with register i at bits [i*WORD_LENGTH +: WORD_LENGTH]

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers are 0, except register 28 = GP_INIT and register 29 = SP_INIT.
  - Write_Ack=0, Busy=0, Write_Onehot=0.
  - Internal clear counter = 0; FSM state = IDLE.
- Register 0 is hardwired:
  - It reads as 0 at all times and is never written.
- FSM states: IDLE and CLEAR.
- In IDLE, with Write_Enable=1 and Clear_Req=0:
  - The write is accepted.
  - If Write_Register != 0, that register takes Write_Data at the edge and the new value appears on Reg_Flat immediately after that edge (write latency 1).
  - Write_Ack=1 for exactly the following cycle.
  - Write_Onehot = 1<<Write_Register for that cycle; it is 0 when Write_Register=0.
- Write to address 0:
  - It is accepted and acknowledged, but no register changes.
- Back-to-back writes:
  - Supported every cycle; Write_Ack stays high across consecutive accepted writes.
- Same address written in consecutive cycles:
  - The last write wins.
- In IDLE, with Clear_Req=1:
  - Move to CLEAR at the edge; Busy=1 from that edge onward.
  - The counter is loaded with 1.
  - Clear takes priority over a simultaneous Write_Enable: that write is dropped and Write_Ack stays 0.
- In CLEAR, on each edge:
  - register[counter] gets its init value: GP_INIT for 28, SP_INIT for 29, 0 for every other register.
  - The counter then increments.
  - On the edge that clears register 31, the FSM returns to IDLE and Busy falls.
  - Busy is therefore high for exactly 31 cycles.
- Inputs during CLEAR:
  - Write_Enable is ignored: no register update and no Write_Ack.
  - Clear_Req is ignored; it does not restart the sequence.
- Registers not yet reached by the sweep keep their values until their turn.
- Reset asserted mid-clear or mid-write:
  - The asynchronous reset overrides everything and restores the full reset state at once.
- Reg_Flat is driven purely from storage: no combinational path from Write_Data (no write-through bypass).
- Bits of Write_Register above 31 cannot occur because NBITS=5; no wrap-around handling is needed.

Test Plan:
1. Reset check: release reset, then read Reg_Flat -> register 28 = 32'h1000_8000, register 29 = 32'h7FFF_FFFC, all other registers = 0; Busy=0, Write_Ack=0.
2. Single write: Write_Enable=1, Write_Register=5, Write_Data=32'hDEAD_BEEF for one cycle -> register 5 = 32'hDEAD_BEEF after the edge; Write_Ack high for 1 cycle; Write_Onehot=32'h0000_0020.
3. Write to register 0: address 0, data 32'hFFFF_FFFF -> register 0 stays 0; Write_Ack=1; Write_Onehot=0.
4. Back-to-back writes: register 3 <- 32'h1, then 32'h2, then register 4 <- 32'h3 in consecutive cycles -> register 3 = 2, register 4 = 3; Write_Ack high for 3 cycles.
5. Bulk clear:
   - Setup: registers 1..31 loaded with 32'hA5A5_A5A5.
   - Stimulus: pulse Clear_Req together with a write to register 7; keep Write_Enable=1 during the sweep.
   - Required response: Busy high for exactly 31 cycles; the write is dropped; no Write_Ack; afterwards registers 28 and 29 hold their init values and all others are 0.
6. Reset mid-clear: assert reset 10 cycles into a clear -> Busy=0 immediately and the full reset state is restored; after release, a write to register 9 succeeds.
